// File: rtl/io_step_seq_if.sv
// Control bundle between io_step_seq and the bus datapath / I/O device.
// start, mem_ready and dev_ready are level qualifiers: start is taken only in IDLE, mem_ready and dev_ready only in T1 and T3.
interface io_step_seq_if;
  logic       start;
  logic [4:0] opcode;
  logic       mem_ready;
  logic       dev_ready;

  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDRin, read;
  logic MDRout, IRin, Gra, Rin, Rout, InPortout, OutPortin;

  logic       busy;
  logic       done;
  logic       err_flag;
  logic [3:0] step;

  modport master (
    input  start, opcode, mem_ready, dev_ready,
    output PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDRin, read,
           MDRout, IRin, Gra, Rin, Rout, InPortout, OutPortin,
           busy, done, err_flag, step
  );

  modport slave (
    output start, opcode, mem_ready, dev_ready,
    input  PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDRin, read,
           MDRout, IRin, Gra, Rin, Rout, InPortout, OutPortin,
           busy, done, err_flag, step
  );
endinterface

// File: rtl/io_step_seq.sv
// Hardwired fetch + in/out sequencer driving the bus datapath strobes.
// Optional macro IO_TIMEOUT_EN adds the T3 device-ready timeout to ERR.
module io_step_seq #(
    parameter logic [4:0] OP_IN       = 5'b10110,
    parameter logic [4:0] OP_OUT      = 5'b10111,
    parameter int         MEM_WAIT    = 0,
    parameter int         DEV_TIMEOUT = 15
) (
    input logic          clock,
    input logic          clear,
    io_step_seq_if.master io
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_DONE = 4'd5;
    localparam logic [3:0] S_ERR  = 4'd6;

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

    if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_bad_mem_wait
        $error("io_step_seq: MEM_WAIT must be 0..15");
    end
    if (DEV_TIMEOUT < 1 || DEV_TIMEOUT > 255) begin : g_bad_dev_timeout
        $error("io_step_seq: DEV_TIMEOUT must be 1..255");
    end

    logic [3:0] state;
    logic [3:0] state_nx;
    logic [3:0] wait_cnt;
    logic       err_q;
    logic       mem_go;
    logic       tmo_hit;
    logic       is_in;
    logic       is_out;

    assign is_in  = (io.opcode == OP_IN);
    assign is_out = (io.opcode == OP_OUT);
    assign mem_go = (wait_cnt >= WAIT_LIMIT) && io.mem_ready;

`ifdef IO_TIMEOUT_EN
    localparam logic [8:0] TMO_LIMIT = 9'(DEV_TIMEOUT);
    logic [7:0] tmo_cnt;

    // tmo_cnt counts completed dev_ready=0 T3 cycles; this cycle is one more.
    assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= TMO_LIMIT;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            tmo_cnt <= 8'd0;
        end else if (state == S_T3 && state_nx == S_T3) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE: state_nx = io.start ? S_T0 : S_IDLE;
            S_T0:   state_nx = S_T1;
            S_T1:   state_nx = mem_go ? S_T2 : S_T1;
            S_T2:   state_nx = S_T3;
            S_T3: begin
                // dev_ready is checked before the timeout so a late ready still succeeds
                if (!(is_in || is_out))  state_nx = S_ERR;
                else if (io.dev_ready)   state_nx = S_DONE;
                else if (tmo_hit)        state_nx = S_ERR;
                else                     state_nx = S_T3;
            end
            S_DONE: state_nx = S_IDLE;
            S_ERR:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;

            // Saturating so the first-cycle decode (wait_cnt==0) never repeats
            if (state == S_T1 && !mem_go) begin
                if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end

            if (state == S_IDLE && io.start) err_q <= 1'b0;
            else if (state_nx == S_ERR)      err_q <= 1'b1;
        end
    end

    always_comb begin
        io.PCout     = 1'b0;
        io.MARin     = 1'b0;
        io.IncPC     = 1'b0;
        io.Zlowin    = 1'b0;
        io.Zlowout   = 1'b0;
        io.PCin      = 1'b0;
        io.MDRin     = 1'b0;
        io.read      = 1'b0;
        io.MDRout    = 1'b0;
        io.IRin      = 1'b0;
        io.Gra       = 1'b0;
        io.Rin       = 1'b0;
        io.Rout      = 1'b0;
        io.InPortout = 1'b0;
        io.OutPortin = 1'b0;
        case (state)
            S_T0: begin
                io.PCout  = 1'b1;
                io.MARin  = 1'b1;
                io.IncPC  = 1'b1;
                io.Zlowin = 1'b1;
            end
            S_T1: begin
                io.read  = 1'b1;
                io.MDRin = 1'b1;
                if (wait_cnt == 4'd0) begin
                    io.Zlowout = 1'b1;
                    io.PCin    = 1'b1;
                end
            end
            S_T2: begin
                io.MDRout = 1'b1;
                io.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_in) begin
                    io.Gra       = 1'b1;
                    io.Rin       = io.dev_ready;
                    io.InPortout = io.dev_ready;
                end else if (is_out) begin
                    io.Gra       = 1'b1;
                    io.Rout      = io.dev_ready;
                    io.OutPortin = io.dev_ready;
                end
            end
            default: ;
        endcase
    end

    assign io.busy     = (state != S_IDLE);
    assign io.done     = (state == S_DONE);
    assign io.err_flag = err_q;
    assign io.step     = state;

endmodule

// File: tb/tb_io_step_seq.sv
// Directed bench for io_step_seq: one MEM_WAIT=0 instance and one MEM_WAIT=2 instance.
module tb_io_step_seq;
  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT = 5'b10111;

  localparam logic [14:0] M_PCOUT = 15'h4000, M_MARIN = 15'h2000, M_INCPC = 15'h1000;
  localparam logic [14:0] M_ZLOWIN = 15'h0800, M_ZLOWOUT = 15'h0400, M_PCIN = 15'h0200;
  localparam logic [14:0] M_MDRIN = 15'h0100, M_READ = 15'h0080, M_MDROUT = 15'h0040;
  localparam logic [14:0] M_IRIN = 15'h0020, M_GRA = 15'h0010, M_RIN = 15'h0008;
  localparam logic [14:0] M_ROUT = 15'h0004, M_INPORTOUT = 15'h0002, M_OUTPORTIN = 15'h0001;
  localparam logic [14:0] M_PORTS = M_RIN | M_ROUT | M_INPORTOUT | M_OUTPORTIN;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  io_step_seq_if if0 ();
  io_step_seq_if if2 ();

  io_step_seq #(.OP_IN(OP_IN), .OP_OUT(OP_OUT), .MEM_WAIT(0), .DEV_TIMEOUT(15))
    dut0 (.clock(clock), .clear(clear), .io(if0.master));
  io_step_seq #(.OP_IN(OP_IN), .OP_OUT(OP_OUT), .MEM_WAIT(2), .DEV_TIMEOUT(15))
    dut2 (.clock(clock), .clear(clear), .io(if2.master));

  logic [14:0] sv0, sv2;
  assign sv0 = {if0.PCout, if0.MARin, if0.IncPC, if0.Zlowin, if0.Zlowout, if0.PCin, if0.MDRin,
                if0.read, if0.MDRout, if0.IRin, if0.Gra, if0.Rin, if0.Rout, if0.InPortout, if0.OutPortin};
  assign sv2 = {if2.PCout, if2.MARin, if2.IncPC, if2.Zlowin, if2.Zlowout, if2.PCin, if2.MDRin,
                if2.read, if2.MDRout, if2.IRin, if2.Gra, if2.Rin, if2.Rout, if2.InPortout, if2.OutPortin};

  task automatic idle_inputs();
    if0.start = 1'b0; if0.opcode = OP_IN; if0.mem_ready = 1'b1; if0.dev_ready = 1'b1;
    if2.start = 1'b0; if2.opcode = OP_IN; if2.mem_ready = 1'b1; if2.dev_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 1'b0;
    #1;
    n_tests++;
    if (if0.step !== 4'd0 || sv0 !== 15'd0 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset0 got step=%0d strb=%h busy=%b done=%b err=%b exp all 0", if0.step, sv0, if0.busy, if0.done, if0.err_flag);
    end
    n_tests++;
    if (if2.step !== 4'd0 || sv2 !== 15'd0 || if2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset2 got step=%0d strb=%h busy=%b exp all 0", if2.step, sv2, if2.busy);
    end
    @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic test_in_nominal();
    logic [3:0]  exp_step [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    logic [14:0] exp_sv   [6] = '{M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN,
                                  M_READ | M_MDRIN | M_ZLOWOUT | M_PCIN,
                                  M_MDROUT | M_IRIN,
                                  M_GRA | M_RIN | M_INPORTOUT,
                                  15'd0, 15'd0};
    int rin_n = 0, done_n = 0, busy_n = 0;
    @(negedge clock);
    if0.opcode = OP_IN; if0.mem_ready = 1'b1; if0.dev_ready = 1'b1; if0.start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      #1;
      n_tests++;
      if (if0.step !== exp_step[c]) begin
        n_fail++;
        $display("FAIL in_step c=%0d got %0d exp %0d", c + 1, if0.step, exp_step[c]);
      end
      n_tests++;
      if (sv0 !== exp_sv[c]) begin
        n_fail++;
        $display("FAIL in_strobes c=%0d got %h exp %h", c + 1, sv0, exp_sv[c]);
      end
      rin_n  += int'(if0.Rin & if0.InPortout);
      done_n += int'(if0.done);
      busy_n += int'(if0.busy);
    end
    n_tests++;
    if (rin_n != 1 || done_n != 1 || busy_n != 5) begin
      n_fail++;
      $display("FAIL in_counts got rin=%0d done=%0d busy=%0d exp 1 1 5", rin_n, done_n, busy_n);
    end
  endtask

  task automatic test_mem_wait();
    int t1_n = 0, rd_n = 0, pcin_n = 0, zl_n = 0, done_n = 0;
    @(negedge clock);
    if2.opcode = OP_IN; if2.mem_ready = 1'b1; if2.dev_ready = 1'b1; if2.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if2.start = 1'b0;
      #1;
      t1_n   += int'(if2.step == 4'd2);
      rd_n   += int'(if2.read);
      pcin_n += int'(if2.PCin);
      zl_n   += int'(if2.Zlowout);
      done_n += int'(if2.done);
      if (c == 2 || c == 3) begin
        n_tests++;
        if (if2.PCin !== (c == 2)) begin
          n_fail++;
          $display("FAIL wait_pcin c=%0d got %b exp %b", c, if2.PCin, (c == 2));
        end
      end
      if (c == 7) begin
        n_tests++;
        if (if2.step !== 4'd5) begin
          n_fail++;
          $display("FAIL wait_done_step got %0d exp 5", if2.step);
        end
      end
    end
    n_tests++;
    if (t1_n != 3 || rd_n != 3 || pcin_n != 1 || zl_n != 1 || done_n != 1) begin
      n_fail++;
      $display("FAIL wait_counts got t1=%0d read=%0d pcin=%0d zlowout=%0d done=%0d exp 3 3 1 1 1",
               t1_n, rd_n, pcin_n, zl_n, done_n);
    end
  endtask

  task automatic test_mem_stall();
    int t1_n = 0, ir_n = 0, done_n = 0;
    @(negedge clock);
    if0.opcode = OP_IN; if0.dev_ready = 1'b1; if0.mem_ready = 1'b0; if0.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      if0.mem_ready = (c >= 6);
      #1;
      t1_n   += int'(if0.step == 4'd2);
      ir_n   += int'(if0.IRin);
      done_n += int'(if0.done);
      if (c == 7) begin
        n_tests++;
        if (if0.step !== 4'd3 || if0.IRin !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_t2 got step=%0d irin=%b exp 3 1", if0.step, if0.IRin);
        end
      end
    end
    n_tests++;
    if (t1_n != 5 || ir_n != 1 || done_n != 1) begin
      n_fail++;
      $display("FAIL stall_counts got t1=%0d irin=%0d done=%0d exp 5 1 1", t1_n, ir_n, done_n);
    end
    if0.mem_ready = 1'b1;
  endtask

  task automatic test_out_wait();
    int gra_n = 0, rout_n = 0, op_n = 0, rin_n = 0;
    @(negedge clock);
    if0.opcode = OP_OUT; if0.mem_ready = 1'b1; if0.dev_ready = 1'b0; if0.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      if0.dev_ready = (c >= 7);
      #1;
      gra_n  += int'(if0.Gra);
      rout_n += int'(if0.Rout);
      op_n   += int'(if0.OutPortin);
      rin_n  += int'(if0.Rin | if0.InPortout);
      if (c >= 4 && c <= 6) begin
        n_tests++;
        if (if0.step !== 4'd4 || sv0 !== M_GRA) begin
          n_fail++;
          $display("FAIL out_wait c=%0d got step=%0d strb=%h exp 4 %h", c, if0.step, sv0, M_GRA);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (sv0 !== (M_GRA | M_ROUT | M_OUTPORTIN)) begin
          n_fail++;
          $display("FAIL out_fire got strb=%h exp %h", sv0, M_GRA | M_ROUT | M_OUTPORTIN);
        end
      end
      if (c == 8) begin
        n_tests++;
        if (if0.step !== 4'd5 || if0.done !== 1'b1) begin
          n_fail++;
          $display("FAIL out_done got step=%0d done=%b exp 5 1", if0.step, if0.done);
        end
      end
    end
    n_tests++;
    if (gra_n != 4 || rout_n != 1 || op_n != 1 || rin_n != 0) begin
      n_fail++;
      $display("FAIL out_counts got gra=%0d rout=%0d outportin=%0d rin=%0d exp 4 1 1 0", gra_n, rout_n, op_n, rin_n);
    end
    if0.dev_ready = 1'b1;
  endtask

  task automatic test_bad_opcode();
    int port_n = 0, done_n = 0;
    @(negedge clock);
    if0.opcode = 5'b00011; if0.mem_ready = 1'b1; if0.dev_ready = 1'b1; if0.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      #1;
      port_n += int'((sv0 & M_PORTS) != 15'd0);
      if (c == 4) begin
        n_tests++;
        if (if0.step !== 4'd4 || sv0 !== 15'd0) begin
          n_fail++;
          $display("FAIL bad_t3 got step=%0d strb=%h exp 4 0", if0.step, sv0);
        end
      end
      if (c == 5 || c == 8) begin
        n_tests++;
        if (if0.step !== ((c == 5) ? 4'd6 : 4'd0) || if0.err_flag !== 1'b1) begin
          n_fail++;
          $display("FAIL bad_err c=%0d got step=%0d err=%b exp %0d 1", c, if0.step, if0.err_flag, (c == 5) ? 6 : 0);
        end
      end
    end
    n_tests++;
    if (port_n != 0) begin
      n_fail++;
      $display("FAIL bad_ports got %0d port cycles exp 0", port_n);
    end
    // A new start clears the sticky error at the T0 edge
    @(negedge clock);
    if0.opcode = OP_IN; if0.start = 1'b1;
    #1;
    n_tests++;
    if (if0.err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_err_hold got %b exp 1", if0.err_flag);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      #1;
      done_n += int'(if0.done);
      if (c == 1) begin
        n_tests++;
        if (if0.step !== 4'd1 || if0.err_flag !== 1'b0) begin
          n_fail++;
          $display("FAIL bad_restart got step=%0d err=%b exp 1 0", if0.step, if0.err_flag);
        end
      end
    end
    n_tests++;
    if (done_n != 1) begin
      n_fail++;
      $display("FAIL bad_restart_done got %0d exp 1", done_n);
    end
  endtask

  task automatic test_timeout();
    int t3_n = 0, port_n = 0;
    @(negedge clock);
    if0.opcode = OP_IN; if0.mem_ready = 1'b1; if0.dev_ready = 1'b0; if0.start = 1'b1;
`ifdef IO_TIMEOUT_EN
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      #1;
      t3_n   += int'(if0.step == 4'd4);
      port_n += int'((sv0 & M_PORTS) != 15'd0);
      if (c == 19) begin
        n_tests++;
        if (if0.step !== 4'd6 || if0.err_flag !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_err got step=%0d err=%b exp 6 1", if0.step, if0.err_flag);
        end
      end
    end
    n_tests++;
    if (t3_n != 15 || port_n != 0) begin
      n_fail++;
      $display("FAIL tmo_counts got t3=%0d ports=%0d exp 15 0", t3_n, port_n);
    end
    // dev_ready arriving on the last allowed T3 cycle still completes
    @(negedge clock);
    if0.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      if0.dev_ready = (c == 18);
      #1;
      if (c == 18) begin
        n_tests++;
        if (if0.step !== 4'd4 || if0.Rin !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_edge got step=%0d rin=%b exp 4 1", if0.step, if0.Rin);
        end
      end
      if (c == 19) begin
        n_tests++;
        if (if0.step !== 4'd5 || if0.err_flag !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_edge_done got step=%0d err=%b exp 5 0", if0.step, if0.err_flag);
        end
      end
    end
`else
    for (int c = 1; c <= 42; c++) begin
      @(negedge clock);
      if0.start = 1'b0;
      if0.dev_ready = (c == 41);
      #1;
      t3_n   += int'(if0.step == 4'd4);
      port_n += int'(if0.Rin);
      if (c == 42) begin
        n_tests++;
        if (if0.step !== 4'd5 || if0.err_flag !== 1'b0) begin
          n_fail++;
          $display("FAIL notmo_done got step=%0d err=%b exp 5 0", if0.step, if0.err_flag);
        end
      end
    end
    n_tests++;
    if (t3_n != 38 || port_n != 1) begin
      n_fail++;
      $display("FAIL notmo_counts got t3=%0d rin=%0d exp 38 1", t3_n, port_n);
    end
`endif
    @(negedge clock);
    if0.dev_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    if0.opcode = OP_IN; if0.mem_ready = 1'b0; if0.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
    @(negedge clock);
    #1;
    n_tests++;
    if (if0.step !== 4'd2 || if0.read !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre got step=%0d read=%b exp 2 1", if0.step, if0.read);
    end
    #1;
    clear = 1'b0;
    #1;
    n_tests++;
    if (if0.step !== 4'd0 || sv0 !== 15'd0 || if0.busy !== 1'b0 || if0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset got step=%0d strb=%h busy=%b done=%b exp 0 0 0 0", if0.step, sv0, if0.busy, if0.done);
    end
    clear = 1'b1;
    if0.mem_ready = 1'b1;
    @(negedge clock);
    #1;
    n_tests++;
    if (if0.step !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_idle got step=%0d exp 0", if0.step);
    end
  endtask

  initial begin
    test_reset();
    test_in_nominal();
    test_mem_wait();
    test_mem_stall();
    test_out_wait();
    test_bad_opcode();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
